// File: rtl/fold_sequencer.sv
// fold_sequencer: control for one SDF FFT stage built on the input-folding
// datapath (N/2-deep delay line plus butterfly). Accepts a valid/ready sample
// stream, drives the datapath enable, the half-frame select and twiddle index,
// marks frame boundaries and flushes the delay line when the stream idles.
//
// Optional feature: define FOLD_SEQ_STATS_EN to build the 16-bit
// completed-frame counter on frame_cnt; otherwise frame_cnt is tied to 0.
module fold_sequencer #(
  parameter int N            = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,       // async, active low
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush_req,
  output logic                     fold_enable,
  output logic                     zero_in,
  output logic                     bf_sel,
  output logic [$clog2(N/2)-1:0]   tw_addr,
  output logic                     pair_valid,
  output logic                     drain_valid,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(N/2);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic [IW-1:0] r_idle_cnt;
  logic [TW-1:0] r_flush_cnt;
  logic          r_flush_latched;

  logic w_acc;
  logic w_boundary;
  logic w_fill_last;
  logic w_frame_last;
  logic w_flush_pend;
  logic w_idle_expire;
  logic w_flush_last;

  // Accept is masked while reset is held so every output sits at its reset value.
  assign w_acc         = in_valid && in_ready && reset;
  assign w_boundary    = (r_state == S_FILL) && (r_cnt == '0) && r_pending;
  assign w_fill_last   = (r_state == S_FILL) && (r_cnt == CW'(N/2 - 1));
  assign w_frame_last  = (r_state == S_COMPUTE) && (r_cnt == CW'(N - 1));
  assign w_flush_pend  = r_flush_latched || flush_req;
  assign w_idle_expire = (r_idle_cnt == IW'(IDLE_TIMEOUT - 1));
  assign w_flush_last  = (r_flush_cnt == TW'(N/2 - 1));

  // Output decode: combinational from registered state and the current accept.
  always_comb begin
    in_ready    = (r_state != S_FLUSH);
    fold_enable = w_acc || (r_state == S_FLUSH);
    zero_in     = (r_state == S_FLUSH);
    bf_sel      = w_acc && (r_state == S_COMPUTE);
    pair_valid  = w_acc && (r_state == S_COMPUTE);
    tw_addr     = '0;
    if (w_acc && (r_state == S_COMPUTE))
      tw_addr = r_cnt[TW-1:0];        // cnt - N/2 for cnt in [N/2, N-1]
    drain_valid = (w_acc && (r_state == S_FILL) && r_pending) || (r_state == S_FLUSH);
    frame_start = w_acc && ((r_state == S_IDLE) || w_boundary);
    frame_done  = w_acc && w_frame_last;
    busy        = (r_state != S_IDLE);
  end

  // Sequencer state: sample counter, half-frame tracking, idle timeout and flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_pending       <= 1'b0;
      r_idle_cnt      <= '0;
      r_flush_cnt     <= '0;
      r_flush_latched <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Nothing in the delay line: a flush request here has nothing to do.
          r_flush_latched <= 1'b0;
          r_idle_cnt      <= '0;
          if (w_acc) begin
            r_cnt   <= CW'(1);
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush_req) r_flush_latched <= 1'b1;
          if (w_acc) begin
            // A boundary sample wins over a same-cycle flush request.
            r_cnt      <= r_cnt + 1'b1;
            r_idle_cnt <= '0;
            if (w_fill_last) begin
              r_state   <= S_COMPUTE;
              r_pending <= 1'b0;
            end
          end else if (w_boundary) begin
            if (w_flush_pend || w_idle_expire) begin
              r_state         <= S_FLUSH;
              r_flush_cnt     <= '0;
              r_flush_latched <= 1'b0;
              r_idle_cnt      <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (flush_req) r_flush_latched <= 1'b1;
          if (w_acc) begin
            if (w_frame_last) begin
              r_cnt     <= '0;
              r_pending <= 1'b1;
              // A flush already requested starts right after the last sample.
              if (w_flush_pend) begin
                r_state         <= S_FLUSH;
                r_flush_cnt     <= '0;
                r_flush_latched <= 1'b0;
              end else begin
                r_state <= S_FILL;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // Zeros are pushed through to drain the last half-frame of differences.
          r_flush_latched <= 1'b0;
          r_flush_cnt     <= r_flush_cnt + 1'b1;
          if (w_flush_last) begin
            r_flush_cnt <= '0;
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FOLD_SEQ_STATS_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter, wraps naturally at 2^16.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_frame_cnt <= '0;
    else if (frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fold_sequencer.sv
// tb_fold_sequencer: table-driven check of fold_sequencer with N=8,
// IDLE_TIMEOUT=4, plus hand-written reset sequences.
module tb_fold_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush_req;
  logic        fold_enable;
  logic        zero_in;
  logic        bf_sel;
  logic [1:0]  tw_addr;
  logic        pair_valid;
  logic        drain_valid;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_cnt;

  fold_sequencer #(.N(8), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush_req(flush_req), .fold_enable(fold_enable), .zero_in(zero_in),
    .bf_sel(bf_sel), .tw_addr(tw_addr), .pair_valid(pair_valid),
    .drain_valid(drain_valid), .frame_start(frame_start), .frame_done(frame_done),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected = {rdy, fe, zi, bf, tw[1:0], pv, dv, fs, fd, busy}
  typedef struct packed {
    logic        v;
    logic        fr;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [10:0] RESET_VEC = 11'b1_0_0_0_00_0_0_0_0_0;

  function automatic logic [10:0] outs();
    return {in_ready, fold_enable, zero_in, bf_sel, tw_addr,
            pair_valid, drain_valid, frame_start, frame_done, busy};
  endfunction

  task automatic add(input logic v, input logic fr,
                     input logic rdy, input logic fe, input logic zi, input logic bf,
                     input int tw, input logic pv, input logic dv, input logic fs,
                     input logic fd, input logic bsy);
    vec_t r;
    r.v   = v;
    r.fr  = fr;
    r.exp = {rdy, fe, zi, bf, 2'(tw), pv, dv, fs, fd, bsy};
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", name, idx, got, want);
    end
  endtask

  task automatic run(input string name, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].v;
      flush_req = tbl[i].fr;
      #1;
      check(name, i, {5'd0, outs()}, {5'd0, tbl[i].exp});
    end
  endtask

  task automatic check_frames(input string name, input int n);
    int want;
`ifdef FOLD_SEQ_STATS_EN
    want = n;
`else
    want = 0;
`endif
    check(name, n, frame_cnt, 16'(want));
  endtask

  // Stall row mid-frame / at boundary: only in_ready and busy high.
  task automatic stall();
    add(0,0, 1,0,0,0,0,0,0,0,0,1);
  endtask

  int a_end, c_end, f_end;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    flush_req = 1'b0;

    // A: 16 continuous samples, idle timeout, flush, back to IDLE.
    add(1,0, 1,1,0,0,0,0,0,1,0,0);
    for (int k = 1; k < 4; k++) add(1,0, 1,1,0,0,0,0,0,0,0,1);
    for (int k = 0; k < 4; k++) add(1,0, 1,1,0,1,k,1,0,0,(k == 3),1);
    add(1,0, 1,1,0,0,0,0,1,1,0,1);
    for (int k = 1; k < 4; k++) add(1,0, 1,1,0,0,0,0,1,0,0,1);
    for (int k = 0; k < 4; k++) add(1,0, 1,1,0,1,k,1,0,0,(k == 3),1);
    for (int k = 0; k < 4; k++) stall();
    for (int k = 0; k < 4; k++) add(0,0, 0,1,1,0,0,0,1,0,0,1);
    add(0,0, 1,0,0,0,0,0,0,0,0,0);
    a_end = tbl.size();

    // flush_req in IDLE is dropped; C: accept/stall alternating for one frame.
    add(0,1, 1,0,0,0,0,0,0,0,0,0);
    add(0,0, 1,0,0,0,0,0,0,0,0,0);
    add(1,0, 1,1,0,0,0,0,0,1,0,0);
    stall();
    for (int k = 1; k < 4; k++) begin
      add(1,0, 1,1,0,0,0,0,0,0,0,1);
      stall();
    end
    for (int k = 0; k < 4; k++) begin
      add(1,0, 1,1,0,1,k,1,0,0,(k == 3),1);
      if (k < 3) stall();
    end
    c_end = tbl.size();

    // D: boundary accept, flush_req at sample 5, flush right after frame_done.
    add(1,0, 1,1,0,0,0,0,1,1,0,1);
    for (int k = 1; k < 4; k++) add(1,0, 1,1,0,0,0,0,1,0,0,1);
    add(1,0, 1,1,0,1,0,1,0,0,0,1);
    add(1,1, 1,1,0,1,1,1,0,0,0,1);
    add(1,0, 1,1,0,1,2,1,0,0,0,1);
    add(1,0, 1,1,0,1,3,1,0,0,1,1);
    for (int k = 0; k < 4; k++) add(1,0, 0,1,1,0,0,0,1,0,0,1);
    add(1,0, 1,1,0,0,0,0,0,1,0,0);
    // F: flush_req with a boundary accept: sample wins, flush after next frame.
    for (int k = 1; k < 4; k++) add(1,0, 1,1,0,0,0,0,0,0,0,1);
    for (int k = 0; k < 4; k++) add(1,0, 1,1,0,1,k,1,0,0,(k == 3),1);
    add(1,1, 1,1,0,0,0,0,1,1,0,1);
    for (int k = 1; k < 4; k++) add(1,0, 1,1,0,0,0,0,1,0,0,1);
    for (int k = 0; k < 4; k++) add(1,0, 1,1,0,1,k,1,0,0,(k == 3),1);
    for (int k = 0; k < 4; k++) add(0,0, 0,1,1,0,0,0,1,0,0,1);
    add(0,0, 1,0,0,0,0,0,0,0,0,0);
    f_end = tbl.size();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 0, {5'd0, outs()}, {5'd0, RESET_VEC});
    check("reset_frame_cnt", 0, frame_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    run("cont16", 0, a_end);
    check_frames("frames_after_cont16", 2);
    run("toggle", a_end, c_end);
    check_frames("frames_after_toggle", 3);
    run("flush_seq", c_end, f_end);
    check_frames("frames_after_flush", 6);

    // E: reset at sample 6 discards the partial frame.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_outs", 6, {5'd0, outs()}, {5'd0, RESET_VEC});
    check("midreset_frame_cnt", 6, frame_cnt, 16'd0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("post_reset_start", 0, {5'd0, outs()}, {5'd0, 11'b1_1_0_0_00_0_0_1_0_0});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("post_reset_stall", 1, {5'd0, outs()}, {5'd0, 11'b1_0_0_0_00_0_0_0_0_1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
